// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CSUM state exists only when BOOT_CHECKSUM_EN is defined.
package boot_pkg;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RELEASE,
    ST_ERR
  } boot_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_RELEASE,
    ST_ERR
  } boot_state_e;
`endif

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  localparam logic [7:0] CSUM_INIT = 8'h00;

endpackage

// File: rtl/boot_word_assembler.sv
// Collects four bytes, least-significant first, into one 32-bit word.
// Used for both the length field and the data words of a boot image.
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {byte_data, shift_q[31:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign word_valid = byte_valid & ~clear & (idx_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_data, shift_q[31:8]};

endmodule

// File: rtl/imem_boot_loader.sv
// Reloads instruction memory from a UART byte stream while holding the core.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e ST_FINISH = ST_CSUM;
`else
  localparam boot_state_e ST_FINISH = ST_RELEASE;
`endif

  boot_state_e       state_q, state_d;
  logic              flash_q, flash_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        rise;
  logic        active;
  logic        data_open;
  logic        tmo_expire;
  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;

  assign rise      = flash & ~flash_q;
  assign data_open = (state_q == ST_DATA) && (word_cnt_q < len_q);
`ifdef BOOT_CHECKSUM_EN
  assign active = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
  assign active = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif
  assign tmo_expire = active & ~byte_valid & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // The assembler only sees bytes that belong to the length field or an unfinished word.
  assign asm_clear = rise | ~((state_q == ST_LEN) | data_open);

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_comb begin
    state_d    = state_q;
    flash_d    = flash;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    tmo_d      = (byte_valid || !active) ? '0 : tmo_q + TMO_W'(1);
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    if (rise) begin
      state_d    = ST_LEN;
      len_d      = '0;
      word_cnt_d = '0;
      tmo_d      = '0;
      addr_d     = '0;
`ifdef BOOT_CHECKSUM_EN
      csum_d     = CSUM_INIT;
`endif
    end else begin
      case (state_q)
        ST_LEN: begin
          if (tmo_expire) begin
            state_d = ST_ERR;
          end else if (asm_valid) begin
            if (asm_word == 32'd0) begin
              state_d = ST_FINISH;
            end else if (asm_word > 32'(MAX_WORDS)) begin
              state_d = ST_ERR;
            end else begin
              len_d   = CNT_W'(asm_word);
              state_d = ST_DATA;
            end
          end
        end
        // The last write is still in flight here, so leave DATA one cycle after it.
        ST_DATA: begin
          if (word_cnt_q == len_q) begin
            state_d = ST_FINISH;
          end else if (tmo_expire) begin
            state_d = ST_ERR;
          end else begin
`ifdef BOOT_CHECKSUM_EN
            if (byte_valid) begin
              csum_d = csum_q ^ byte_data;
            end
`endif
            if (asm_valid) begin
              we_d       = 1'b1;
              addr_d     = word_cnt_q[ADDR_W-1:0];
              wdata_d    = asm_word;
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        ST_CSUM: begin
          if (tmo_expire) begin
            state_d = ST_ERR;
          end else if (byte_valid) begin
            state_d = (byte_data == csum_q) ? ST_RELEASE : ST_ERR;
          end
        end
`endif
        ST_RELEASE: state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flash_q    <= 1'b0;
      len_q      <= '0;
      word_cnt_q <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= CSUM_INIT;
`endif
    end else begin
      state_q    <= state_d;
      flash_q    <= flash_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_hold    = (state_q != ST_IDLE);
  assign cpu_restart = (state_q == ST_RELEASE);
  assign done        = (state_q == ST_RELEASE);
  assign error       = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised and directed bench for imem_boot_loader, checked every cycle
// against a byte-stream reference model (honours BOOT_CHECKSUM_EN).
module tb_imem_boot_loader;

  localparam int ADDR_W = 4;
  localparam int MAXW   = 4;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              flash;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              cpu_restart;
  logic              done;
  logic              error;

  imem_boot_loader #(
    .ADDR_W         (ADDR_W),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flash       (flash),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_hold    (cpu_hold),
    .cpu_restart (cpu_restart),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;
  bit gap_en = 1'b0;
  logic [7:0] csum_sink;

  int          wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          done_cnt    = 0;
  int          restart_cnt = 0;

  // Reference model: tracks the load as a count of bytes consumed
  bit          m_flash_prev;
  bit          m_loading, m_release, m_error, m_finish, m_csum_wait;
  int          m_nbytes, m_len, m_words, m_idle;
  logic [31:0] m_acc;
  logic [7:0]  m_xor;
  logic        exp_we;
  int          exp_addr;
  logic [31:0] exp_wdata;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_xor(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task m_reset();
    m_flash_prev = 1'b0;
    m_loading = 1'b0; m_release = 1'b0; m_error = 1'b0;
    m_finish = 1'b0; m_csum_wait = 1'b0;
    m_nbytes = 0; m_len = 0; m_words = 0; m_idle = 0;
    m_acc = '0; m_xor = 8'h00;
    exp_we = 1'b0; exp_addr = 0; exp_wdata = '0;
  endtask

  task m_finish_load();
`ifdef BOOT_CHECKSUM_EN
    m_csum_wait = 1'b1;
`else
    m_loading = 1'b0;
    m_release = 1'b1;
`endif
  endtask

  task m_fail_load();
    m_loading = 1'b0;
    m_error   = 1'b1;
  endtask

  task m_consume(input logic [7:0] b);
    int k;
    if (m_csum_wait) begin
      m_loading = 1'b0;
      if (b == m_xor) m_release = 1'b1;
      else m_error = 1'b1;
    end else if (m_nbytes < 4) begin
      m_acc = m_acc | (32'(b) << (8 * m_nbytes));
      m_nbytes++;
      if (m_nbytes == 4) begin
        m_len = int'(m_acc);
        m_acc = '0;
        if (m_acc == 32'd0 && m_len == 0) m_finish_load();
        else if (m_len > MAXW || m_len < 0) m_fail_load();
      end
    end else begin
      k = (m_nbytes - 4) % 4;
      m_acc = m_acc | (32'(b) << (8 * k));
      m_xor = m_xor ^ b;
      m_nbytes++;
      if (k == 3) begin
        exp_we    = 1'b1;
        exp_addr  = m_words;
        exp_wdata = m_acc;
        m_acc     = '0;
        m_words++;
        if (m_words == m_len) m_finish = 1'b1;
      end
    end
  endtask

  task m_step(input logic fl, input logic bv, input logic [7:0] bd);
    bit rise;
    exp_we = 1'b0;
    rise = fl && !m_flash_prev;
    m_flash_prev = fl;
    if (rise) begin
      m_reset();
      m_flash_prev = fl;
      m_loading = 1'b1;
    end else if (m_release) begin
      m_release = 1'b0;
    end else if (m_loading) begin
      if (m_finish) begin
        m_finish = 1'b0;
        m_finish_load();
      end else if (bv) begin
        m_idle = 0;
        m_consume(bd);
      end else begin
        m_idle++;
        if (m_idle == TMO) m_fail_load();
      end
    end
  endtask

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step(flash, byte_valid, byte_data);
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check_output("imem_we", 32'(imem_we), 32'(exp_we));
      check_output("cpu_hold", 32'(cpu_hold), 32'(m_loading | m_release | m_error));
      check_output("cpu_restart", 32'(cpu_restart), 32'(m_release));
      check_output("done", 32'(done), 32'(m_release));
      check_output("error", 32'(error), 32'(m_error));
      if (exp_we) begin
        check_output("imem_addr", 32'(imem_addr), 32'(exp_addr));
        check_output("imem_wdata", imem_wdata, exp_wdata);
      end
      if (imem_we) begin
        wr_addr_log.push_back(int'(imem_addr));
        wr_data_log.push_back(imem_wdata);
      end
      if (done) done_cnt++;
      if (cpu_restart) restart_cnt++;
    end
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task idle(input int n);
    repeat (n) tick();
  endtask

  task send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    if (gap_en) idle($urandom_range(0, 2));
  endtask

  task send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task pulse_flash();
    flash = 1'b1;
    tick();
    flash = 1'b0;
    tick();
  endtask

  task finish_csum(input logic [7:0] x);
`ifdef BOOT_CHECKSUM_EN
    send_byte(x);
`else
    csum_sink = x;
`endif
  endtask

  task clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  initial begin : main
    int d0, r0;
    rst = 1'b1; flash = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold", 32'(cpu_hold), 32'd0);
    check_output("reset_we", 32'(imem_we), 32'd0);
    check_output("reset_addr", 32'(imem_addr), 32'd0);
    check_output("reset_wdata", imem_wdata, 32'd0);
    check_output("reset_done", 32'(done | cpu_restart), 32'd0);
    check_output("reset_error", 32'(error), 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    send_word(32'h0000_0002);

    // Basic two-word load
    clear_logs(); d0 = done_cnt; r0 = restart_cnt;
    pulse_flash();
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    finish_csum(8'hB0);
    idle(4);
    check_output("basic_nwrites", 32'(wr_data_log.size()), 32'd2);
    if (wr_data_log.size() == 2) begin
      check_output("basic_addr0", 32'(wr_addr_log[0]), 32'd0);
      check_output("basic_data0", wr_data_log[0], 32'h0010_0513);
      check_output("basic_addr1", 32'(wr_addr_log[1]), 32'd1);
      check_output("basic_data1", wr_data_log[1], 32'h0020_0593);
    end
    check_output("basic_done", 32'(done_cnt - d0), 32'd1);
    check_output("basic_restart", 32'(restart_cnt - r0), 32'd1);
    check_output("basic_hold_low", 32'(cpu_hold), 32'd0);

    // Zero-length image
    clear_logs(); d0 = done_cnt;
    pulse_flash();
    send_word(32'd0);
    finish_csum(8'h00);
    idle(4);
    check_output("zero_nwrites", 32'(wr_data_log.size()), 32'd0);
    check_output("zero_done", 32'(done_cnt - d0), 32'd1);

    // Oversize image
    clear_logs();
    pulse_flash();
    send_word(32'd5);
    send_word(32'h1234_5678);
    idle(3);
    check_output("over_error", 32'(error), 32'd1);
    check_output("over_hold", 32'(cpu_hold), 32'd1);
    check_output("over_nwrites", 32'(wr_data_log.size()), 32'd0);

    // Inter-byte timeout, then recovery
    pulse_flash();
    check_output("recover_error_clr", 32'(error), 32'd0);
    send_word(32'd2);
    send_word(32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(TMO + 2);
    check_output("tmo_error", 32'(error), 32'd1);
    clear_logs(); d0 = done_cnt;
    pulse_flash();
    check_output("tmo_error_clr", 32'(error), 32'd0);
    send_word(32'd2);
    send_word(32'h0000_0001);
    send_word(32'h8000_0000);
    finish_csum(8'h81);
    idle(4);
    check_output("tmo_recover_done", 32'(done_cnt - d0), 32'd1);
    check_output("tmo_recover_nwrites", 32'(wr_data_log.size()), 32'd2);

    // Restart mid-word; the coincident byte is discarded
    clear_logs(); d0 = done_cnt;
    pulse_flash();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    flash = 1'b1; byte_valid = 1'b1; byte_data = 8'hCC;
    tick();
    flash = 1'b0; byte_valid = 1'b0;
    tick();
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    finish_csum(8'h22);
    idle(4);
    check_output("restart_nwrites", 32'(wr_data_log.size()), 32'd1);
    if (wr_data_log.size() == 1) begin
      check_output("restart_addr", 32'(wr_addr_log[0]), 32'd0);
      check_output("restart_data", wr_data_log[0], 32'hDEAD_BEEF);
    end
    check_output("restart_done", 32'(done_cnt - d0), 32'd1);

`ifdef BOOT_CHECKSUM_EN
    d0 = done_cnt;
    pulse_flash();
    send_word(32'd1);
    send_word(32'h0804_0201);
    send_byte(8'h0F);
    idle(4);
    check_output("csum_ok_done", 32'(done_cnt - d0), 32'd1);
    check_output("csum_ok_error", 32'(error), 32'd0);
    r0 = restart_cnt;
    pulse_flash();
    send_word(32'd1);
    send_word(32'h0804_0201);
    send_byte(8'h0E);
    idle(4);
    check_output("csum_bad_error", 32'(error), 32'd1);
    check_output("csum_bad_restart", 32'(restart_cnt - r0), 32'd0);
`endif

    // Asynchronous reset in the middle of a data word
    clear_logs();
    pulse_flash();
    send_word(32'd2);
    send_word(32'h5555_AAAA);
    send_byte(8'h01);
    #3;
    rst = 1'b1;
    #1;
    check_output("arst_hold", 32'(cpu_hold), 32'd0);
    check_output("arst_we", 32'(imem_we), 32'd0);
    check_output("arst_addr", 32'(imem_addr), 32'd0);
    check_output("arst_error", 32'(error | done | cpu_restart), 32'd0);
    tick();
    rst = 1'b0;
    clear_logs();
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    idle(2);
    check_output("arst_ignored", 32'(wr_data_log.size()), 32'd0);
    check_output("arst_hold_after", 32'(cpu_hold), 32'd0);

    // Randomised loads, some oversize, some aborted, some with bad checksums
    gap_en = 1'b1;
    for (int it = 0; it < 14; it++) begin
      int n;
      bit abort;
      logic [7:0] x;
      logic [31:0] w;
      n = $urandom_range(0, 5);
      abort = ($urandom_range(0, 5) == 0);
      x = 8'h00;
      pulse_flash();
      send_word(32'(n));
      if (n <= MAXW) begin
        if (abort && n > 0) begin
          send_byte(8'($urandom));
          send_byte(8'($urandom));
          idle(TMO + 3);
        end else begin
          for (int k = 0; k < n; k++) begin
            w = $urandom;
            x = x ^ byte_xor(w);
            send_word(w);
          end
          finish_csum(($urandom_range(0, 3) == 0) ? ~x : x);
        end
      end
      idle($urandom_range(2, 6));
      send_byte(8'($urandom));
      send_byte(8'($urandom));
    end

    idle(5);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Controller that reloads instruction memory over UART while the pipeline is held.
- Sits between uart_interface (byte stream) and the fetch-stage instruction memory write port.
- Asserts a hold to the pipeline during a load, then pulses a restart so fetch resumes at PC 0.
- Validates length, inter-byte timeout and (optionally) checksum; on error the core stays held.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- MAX_WORDS, 1024, largest accepted image in words; must be ≤ 2^ADDR_W.
- TIMEOUT_CYCLES, 5_000_000, max clk cycles between bytes once a load has started.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- flash  in  1  load request; rising edge starts or restarts a load
- byte_valid  in  1  one-cycle strobe, byte_data valid (uart byte_received)
- byte_data  in  8  received byte
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  word address for write
- imem_wdata  out  32  word to write
- cpu_hold  out  1  stall/hold whole pipeline (PC and all stage registers)
- cpu_restart  out  1  one-cycle pulse: pipeline resets to PC 0
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky load error flag

Behaviour:
- Reset (async): state IDLE; all outputs 0; byte counter, word counter, length, timeout counter, checksum cleared; flash edge register cleared.
- flash is registered once; rise = flash & ~flash_q.
- Protocol, all fields little-endian: 4 length bytes giving N words, then N×4 data bytes, then a checksum byte (feature only).
- States: IDLE, LEN, DATA, CSUM, RELEASE, ERR.
- IDLE: cpu_hold=0; bytes ignored; flash rise -> LEN, cpu_hold=1, error cleared, counters cleared.
- LEN: collect 4 bytes.
  - N=0 -> RELEASE (or CSUM with feature).
  - N>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: the 4th byte of a word drives imem_we=1 for exactly one cycle on the next cycle, with imem_wdata equal to the assembled word and imem_addr equal to the word index.
  - imem_addr increments by 1 after each write and starts at 0.
  - After word N-1 is written -> RELEASE (or CSUM).
- RELEASE: one cycle; cpu_restart=1, done=1, cpu_hold=1 in this cycle. Next cycle -> IDLE with cpu_hold=0.
- Timeout: counter clears on every byte_valid and counts only in LEN/DATA/CSUM. On reaching TIMEOUT_CYCLES-1 -> ERR.
- ERR: error=1 (sticky), cpu_hold=1, imem_we=0; bytes ignored. Leaves only on flash rise (-> LEN, error cleared) or rst.
- flash rise in LEN/DATA/CSUM restarts the load: go to LEN, counters and address cleared, no write issued for a partial word.
- byte_valid coincident with a flash rise: the byte is discarded.
- byte_valid coincident with timeout expiry: the byte wins, counter clears.
- rst mid-load: immediate return to IDLE with cpu_hold=0. Memory contents are left partially written, with no guarantee of consistency.
- imem_we never asserts outside DATA; at most one write per 4 bytes.

Optional Feature:
- Macro BOOT_CHECKSUM_EN.
- Defined: a running XOR of all data bytes (length bytes excluded), initialised to 0x00. After the last word (or immediately when N=0) the FSM enters CSUM and waits for one byte.
  - Byte equal to the XOR -> RELEASE.
  - Byte not equal -> ERR; words already written remain, core stays held.
- Undefined: CSUM state and XOR register are absent; after the last word go directly to RELEASE.

Decomposition:
- Package boot_pkg holds:
  - the boot_state_e enum;
  - LEN_BYTES=4 and WORD_BYTES=4;
  - the checksum init value 8'h00.
- Sub-module boot_word_assembler:
  - 2-bit byte index plus 32-bit little-endian shift/insert register;
  - word_valid pulse on the 4th byte;
  - synchronous clear.
- It is reused for both the length field and data words.

Test Plan:
- Basic load: flash rise, bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 -> imem_we pulses at addr 0 (wdata 0x00100513) and addr 1 (0x00200593); then done and cpu_restart for 1 cycle each; cpu_hold falls the cycle after.
- Zero/oversize length: N=0 -> done with no imem_we. With MAX_WORDS=4, N=5 -> error=1, cpu_hold stays 1, no imem_we.
- Timeout: TIMEOUT_CYCLES=100; send 6 of 8 data bytes then idle 100 cycles -> ERR. A new flash rise then clears error and a full load succeeds.
- Restart mid-load: flash rise after 2 data bytes, then a full 1-word image -> the single write lands at addr 0 with the new word; no write of the partial word.
- Checksum (BOOT_CHECKSUM_EN): N=1, data 01 02 04 08, csum 0F -> done. Same image with csum 0E -> error=1, no cpu_restart.
- Async reset during DATA: rst pulse mid-cycle -> all outputs 0 immediately; bytes then ignored until the next flash rise.
